// File: rtl/itch_arb_pkg.sv
// Shared definitions for the ITCH feed arbiter: FSM state encoding, default
// parameter values and the feed-index type used by the arbiter and selector.
package itch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } arb_state_t;

    // One bit selects between feed 0 and feed 1
    typedef logic feed_idx_t;

    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_MAX_LEN    = 64;
    localparam int DEF_STALL_MAX  = 8;

    function automatic logic [1:0] feed_onehot(input feed_idx_t f);
        return f ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/itch_rr_pick.sv
// Two-way combinational round-robin selector.
// Ports:
//   req         - request vector, bit i set when feed i has a byte waiting
//   last_served - feed that owned the parser most recently
//   gnt         - one-hot winner, 0 when nobody requests
module itch_rr_pick
    import itch_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: the feed that was not served last wins
            2'b11:   gnt = feed_onehot(~last_served);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/itch_feed_arbiter.sv
// Merges two ITCH byte feeds onto a single parser byte stream, one whole
// message at a time, with a mandatory idle gap between messages so the
// parser can fall back to waiting for a type byte.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   s_valid     - per-feed byte valid
//   s_data      - per-feed byte, feed i on bits [8*i +: 8]
//   s_last      - per-feed last-byte-of-message flag
//   s_ready     - per-feed accept (only the owning feed, only while streaming)
//   m_byte      - forwarded byte, registered
//   m_valid     - forwarded byte strobe, registered
//   grant       - one-hot owning feed, 0 when no feed owns the parser
//   err_pulse   - single-cycle pulse on truncation or stall abort
//   msg_count   - messages completed with s_last, wrapping
module itch_feed_arbiter
    import itch_arb_pkg::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int STALL_MAX  = DEF_STALL_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  s_valid,
    input  logic [15:0] s_data,
    input  logic [1:0]  s_last,
    output logic [1:0]  s_ready,
    output logic [7:0]  m_byte,
    output logic        m_valid,
    output logic [1:0]  grant,
    output logic        err_pulse,
    output logic [15:0] msg_count
);

    // Compare against "one less than the limit" so the decision is taken on
    // the edge where the counter would reach the limit.
    localparam logic [6:0] LEN_LAST   = 7'(MAX_LEN - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);
    localparam logic [7:0] GAP_LAST   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    arb_state_t state, state_next;
    logic [1:0] rst_sync;
    logic       run;
    feed_idx_t  owner, last_served;
    logic [6:0] len_cnt;
    logic [7:0] stall_cnt;
    logic [7:0] gap_cnt;
    logic [1:0] pick;
    logic       owner_valid, owner_last;
    logic [7:0] owner_data;
    logic       take, accept, complete, trunc, stall_abort;

    // Reset release is re-timed to clk; arbitration starts only once the
    // second synchroniser stage has gone high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    itch_rr_pick u_pick (
        .req         (s_valid),
        .last_served (last_served),
        .gnt         (pick)
    );

    assign owner_valid = s_valid[owner];
    assign owner_last  = s_last[owner];
    assign owner_data  = owner ? s_data[15:8] : s_data[7:0];

    assign s_ready = (state == STREAM) ? feed_onehot(owner) : 2'b00;
    assign grant   = (state == STREAM) ? feed_onehot(owner) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        take        = 1'b0;
        accept      = 1'b0;
        complete    = 1'b0;
        trunc       = 1'b0;
        stall_abort = 1'b0;
        case (state)
            IDLE: begin
                if (run && (s_valid != 2'b00)) begin
                    take       = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (owner_valid) begin
                    accept = 1'b1;
                    // s_last on the MAX_LEN-th byte is a normal completion
                    if (owner_last)              complete = 1'b1;
                    else if (len_cnt == LEN_LAST) trunc   = 1'b1;
                    if (complete || trunc) state_next = GAP;
                end else if (stall_cnt == STALL_LAST) begin
                    stall_abort = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            last_served <= 1'b1;
            len_cnt     <= '0;
            stall_cnt   <= '0;
            gap_cnt     <= '0;
            msg_count   <= '0;
            m_valid     <= 1'b0;
            m_byte      <= 8'h00;
            err_pulse   <= 1'b0;
        end else begin
            m_valid   <= accept;
            m_byte    <= accept ? owner_data : 8'h00;
            err_pulse <= trunc | stall_abort;

            if (take) begin
                owner     <= (pick == 2'b10);
                len_cnt   <= '0;
                stall_cnt <= '0;
            end else if (accept) begin
                len_cnt   <= len_cnt + 7'd1;
                stall_cnt <= '0;
            end else if (state == STREAM) begin
                stall_cnt <= stall_cnt + 8'd1;
            end

            // Every way out of STREAM counts as having served this feed
            if (complete || trunc || stall_abort) last_served <= owner;
            if (complete) msg_count <= msg_count + 16'd1;

            if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
            else              gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_itch_feed_arbiter.sv
module tb_itch_feed_arbiter;

    localparam int GAP  = 2;
    localparam int MAXL = 64;
    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic [7:0]  m_byte;
    logic        m_valid;
    logic [1:0]  grant;
    logic        err_pulse;
    logic [15:0] msg_count;

    always #5 clk = ~clk;

    itch_feed_arbiter #(.GAP_CYCLES(GAP), .MAX_LEN(MAXL), .STALL_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_byte(m_byte), .m_valid(m_valid), .grant(grant),
        .err_pulse(err_pulse), .msg_count(msg_count)
    );

    // Feed byte store: each entry may be preceded by idle cycles (pre), and a
    // "once" entry is offered for a single cycle only.
    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         once;
        int         pre;
    } ent_t;

    typedef struct {
        int feed;
        int len;
        bit last;
        int fwd;
        int err;
        int inc;
    } vec_t;

    ent_t fmem [2][512];
    int   flen [2];
    int   fpos [2];
    int   stall_left [2];
    bit   loaded [2];
    bit   presented [2];
    bit   hs [2];

    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [1:0] gtrace[$];
    logic [7:0] exp_q[$];
    int         mlen_q[$];

    int tests = 0, fails = 0;
    int cyc = 0, err_cnt = 0, err_cyc = 0, last_hs_cyc = 0;
    int lat_bad = 0, once_acc = 0, ready_bad = 0, exp_msgs = 0;
    bit exp_v = 0;
    logic [7:0] exp_b = 8'h00;
    logic [1:0] gprev = 2'b00;

    function automatic logic [7:0] mb(input int f, input int id, input int k);
        if (k == 0) return 8'h44;
        return 8'((k + id * 7 + f * 100) & 255);
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic add_msg(input int f, input int id, input int len, input bit last, input bit stalls);
        for (int k = 0; k < len && k <= MAXL; k++) begin
            ent_t e;
            e.data = mb(f, id, k);
            e.last = last && (k == len - 1);
            e.once = (k == MAXL);
            e.pre  = (stalls && k > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, SMAX - 2)) : 0;
            fmem[f][flen[f]] = e;
            flen[f]++;
        end
    endtask

    // Reference: a message forwards its first min(len, MAX_LEN) bytes
    task automatic exp_msg(input int f, input int id, input int len);
        int n;
        n = (len < MAXL) ? len : MAXL;
        for (int k = 0; k < n; k++) exp_q.push_back(mb(f, id, k));
        mlen_q.push_back(n);
    endtask

    task automatic new_test();
        out_q.delete(); out_cyc.delete(); gtrace.delete(); exp_q.delete(); mlen_q.delete();
        err_cnt = 0; lat_bad = 0; once_acc = 0; ready_bad = 0;
        for (int i = 0; i < 2; i++) begin
            flen[i] = 0; fpos[i] = 0; loaded[i] = 0; presented[i] = 0; hs[i] = 0; stall_left[i] = 0;
        end
        s_valid = 2'b00; s_last = 2'b00; s_data = 16'h0000;
    endtask

    // One clock: sample registered outputs, retire last cycle's transfers,
    // present the next bytes, note which will transfer on the coming edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_valid !== exp_v || m_byte !== (exp_v ? exp_b : 8'h00)) lat_bad++;
        if (m_valid) begin
            out_q.push_back(m_byte);
            out_cyc.push_back(cyc);
        end
        if (err_pulse) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (s_ready == 2'b11 || grant == 2'b11 || s_ready != grant) ready_bad++;
        if (grant != gprev) begin
            gtrace.push_back(grant);
            gprev = grant;
        end
        exp_v = 0;
        exp_b = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (presented[i] && (hs[i] || fmem[i][fpos[i]].once)) begin
                if (hs[i] && fmem[i][fpos[i]].once) once_acc++;
                fpos[i]++;
                loaded[i] = 0;
            end
            presented[i] = 0;
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            s_data[8*i +: 8] = 8'h00;
            if (fpos[i] < flen[i]) begin
                if (!loaded[i]) begin
                    stall_left[i] = fmem[i][fpos[i]].pre;
                    loaded[i] = 1;
                end
                if (stall_left[i] > 0) begin
                    stall_left[i]--;
                end else begin
                    s_valid[i] = 1'b1;
                    s_last[i]  = fmem[i][fpos[i]].last;
                    s_data[8*i +: 8] = fmem[i][fpos[i]].data;
                    presented[i] = 1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            hs[i] = s_valid[i] && s_ready[i];
            if (hs[i]) begin
                exp_v = 1;
                exp_b = fmem[i][fpos[i]].data;
                last_hs_cyc = cyc;
            end
        end
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic cmp_stream(input string name);
        int bad;
        bad = 0;
        check({name, "_count"}, out_q.size(), exp_q.size());
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
            if (out_q[k] !== exp_q[k]) bad++;
        check({name, "_data"}, bad, 0);
        check({name, "_latency"}, lat_bad, 0);
        check({name, "_handshake"}, once_acc + ready_bad, 0);
    endtask

    function automatic int gap_viol();
        int viol, idx;
        viol = 0;
        idx = 0;
        foreach (mlen_q[m]) begin
            if (m > 0 && idx > 0 && idx < out_cyc.size())
                if (out_cyc[idx] - out_cyc[idx-1] - 1 < GAP) viol++;
            idx += mlen_q[m];
        end
        return viol;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        exp_v = 0;
        new_test();
        exp_msgs = 0;
        drain(2);
        rst_n = 1'b1;
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, i0, i1, turn, f, tcode;
        int len0 [8];
        int len1 [8];

        vecs[0] = '{feed: 0, len: 9,  last: 1, fwd: 9,  err: 0, inc: 1};
        vecs[1] = '{feed: 1, len: 70, last: 0, fwd: 64, err: 1, inc: 0};
        vecs[2] = '{feed: 0, len: 64, last: 1, fwd: 64, err: 0, inc: 1};
        vecs[3] = '{feed: 1, len: 65, last: 1, fwd: 64, err: 1, inc: 0};
        vecs[4] = '{feed: 1, len: 1,  last: 1, fwd: 1,  err: 0, inc: 1};
        vecs[5] = '{feed: 0, len: 63, last: 0, fwd: 63, err: 1, inc: 0};
        vecs[6] = '{feed: 0, len: 2,  last: 1, fwd: 2,  err: 0, inc: 1};

        // Reset state with both feeds requesting, then round-robin start
        rst_n = 1'b0;
        new_test();
        add_msg(0, 0, 9, 1, 0);
        add_msg(1, 1, 9, 1, 0);
        exp_msg(0, 0, 9);
        exp_msg(1, 1, 9);
        drain(2);
        check("reset_outputs", int'({grant, s_ready, m_valid, m_byte, err_pulse, msg_count}), 0);
        rst_n = 1'b1;
        step();
        check("grant_after_first_edge", int'(grant), 0);
        run_until(18, 80);
        drain(8);
        exp_msgs = 2;
        cmp_stream("rr");
        tcode = 0;
        foreach (gtrace[k]) tcode = tcode * 4 + int'(gtrace[k]);
        check("rr_grant_trace_len", gtrace.size(), 4);
        check("rr_grant_trace", tcode, 'b01_00_10_00);
        check("rr_gap", gap_viol(), 0);
        check("rr_msg_count", int'(msg_count), exp_msgs);

        // Single-feed message table
        foreach (vecs[v]) begin
            new_test();
            add_msg(vecs[v].feed, v, vecs[v].len, vecs[v].last, 0);
            exp_msg(vecs[v].feed, v, vecs[v].len);
            run_until(vecs[v].fwd, vecs[v].len + 60);
            drain(16);
            exp_msgs += vecs[v].inc;
            cmp_stream($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err", v), err_cnt, vecs[v].err);
            check($sformatf("vec%0d_msg_count", v), int'(msg_count), exp_msgs);
        end

        // Stall abort: 3 bytes then silence; abort after STALL_MAX idle cycles
        new_test();
        add_msg(0, 30, 3, 0, 0);
        exp_msg(0, 30, 3);
        run_until(3, 30);
        drain(16);
        cmp_stream("stall");
        check("stall_err", err_cnt, 1);
        check("stall_err_timing", err_cyc - last_hs_cyc, SMAX + 1);
        check("stall_grant_released", int'(grant), 0);
        check("stall_msg_count", int'(msg_count), exp_msgs);
        new_test();
        add_msg(0, 31, 5, 1, 0);
        exp_msg(0, 31, 5);
        run_until(5, 40);
        drain(8);
        exp_msgs++;
        cmp_stream("after_stall");

        // Reset in the middle of a message
        new_test();
        add_msg(0, 40, 9, 1, 0);
        run_until(4, 40);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", int'({grant, s_ready, m_valid, m_byte, err_pulse, msg_count}), 0);
        exp_v = 0;
        new_test();
        exp_msgs = 0;
        drain(2);
        rst_n = 1'b1;
        step();
        check("midreset_m_valid_after_release", int'(m_valid), 0);
        add_msg(0, 41, 9, 1, 0);
        exp_msg(0, 41, 9);
        run_until(9, 60);
        drain(8);
        exp_msgs++;
        cmp_stream("post_reset");
        check("post_reset_err", err_cnt, 0);
        check("post_reset_msg_count", int'(msg_count), exp_msgs);

        // Randomised backlog on both feeds with short mid-message stalls
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n0 = $urandom_range(2, 6);
            n1 = $urandom_range(2, 6);
            for (int j = 0; j < n0; j++) begin
                len0[j] = $urandom_range(1, MAXL);
                add_msg(0, 10 + j, len0[j], 1, 1);
            end
            for (int j = 0; j < n1; j++) begin
                len1[j] = $urandom_range(1, MAXL);
                add_msg(1, 20 + j, len1[j], 1, 1);
            end
            // Message-level model: alternate while both have backlog
            i0 = 0; i1 = 0; turn = 0;
            while (i0 < n0 || i1 < n1) begin
                if (i0 < n0 && i1 < n1) f = turn;
                else f = (i0 < n0) ? 0 : 1;
                if (f == 0) begin exp_msg(0, 10 + i0, len0[i0]); i0++; end
                else        begin exp_msg(1, 20 + i1, len1[i1]); i1++; end
                turn = 1 - f;
            end
            run_until(exp_q.size(), 6000);
            drain(10);
            cmp_stream($sformatf("rand%0d", r));
            check($sformatf("rand%0d_gap", r), gap_viol(), 0);
            check($sformatf("rand%0d_err", r), err_cnt, 0);
            check($sformatf("rand%0d_msg_count", r), int'(msg_count), n0 + n1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/itch_feed_arbiter.md
ITCH_FEED_ARBITER -- requirements
Module: itch_feed_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2: minimum idle cycles on m_valid between consecutive forwarded messages.
REQ-002 Parameter MAX_LEN, default 64: maximum bytes per message before forced truncation.
REQ-003 Parameter STALL_MAX, default 8: maximum consecutive mid-message cycles with s_valid low before abort.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  2  per-feed byte valid (feed 0, feed 1).
REQ-007 s_data  input  2x8  per-feed ITCH byte.
REQ-008 s_last  input  2  per-feed last-byte-of-message flag, qualified by s_valid.
REQ-009 s_ready  output  2  per-feed accept; a byte transfers when s_valid[i] and s_ready[i] are both high.
REQ-010 m_byte  output  8  byte to parser byte_in.
REQ-011 m_valid  output  1  strobe to parser valid_in.
REQ-012 grant  output  2  one-hot owning feed; 0 when no feed owns the parser.
REQ-013 err_pulse  output  1  one-cycle pulse on truncation or stall abort.
REQ-014 msg_count  output  16  count of messages completed with s_last, wraps 0xFFFF->0.

Function
REQ-015 States IDLE, STREAM, GAP; state encoding comes from the shared package.
REQ-016 IDLE: if no s_valid is high, remain in IDLE; otherwise grant one feed and enter STREAM on the next edge.
REQ-017 Arbitration is round-robin at message granularity: with both requesting, grant the feed not served last; after reset, feed 0 has priority.
REQ-018 A single requester is granted regardless of round-robin history.
REQ-019 STREAM: s_ready[g]=1 combinationally for the granted feed g only; s_ready of the other feed is 0.
REQ-020 Each accepted byte appears on m_byte with m_valid=1 exactly one cycle after acceptance (registered, latency 1).
REQ-021 m_valid=0 and m_byte=0 in every cycle with no accepted byte in the preceding cycle.
REQ-022 A 7-bit length counter clears on grant and increments per accepted byte.
REQ-023 An accepted byte with s_last=1 ends the message: increment msg_count, record last-served feed, go to GAP.
REQ-024 If the length counter reaches MAX_LEN without s_last: deassert s_ready, pulse err_pulse, and go to GAP; msg_count is unchanged.
REQ-025 In STREAM, a stall counter increments on each cycle with s_valid[g]=0 and clears on acceptance.
REQ-026 When the stall count reaches STALL_MAX: pulse err_pulse and go to GAP; msg_count is unchanged.
REQ-027 Truncated and aborted messages also update last-served feed.
REQ-028 GAP: s_ready=0 and grant=0; count GAP_CYCLES cycles, then go to IDLE. GAP_CYCLES=0 returns to IDLE on the next edge.
REQ-029 The gap lets the parser return to its type-byte-wait state; GAP is never skipped after STREAM.
REQ-030 A non-granted feed's s_valid is ignored and never causes an error.
REQ-031 If s_last and the MAX_LEN-th byte coincide, treat it as a normal completion: no err_pulse, msg_count increments.

Reset
REQ-032 When rst_n is low, all registers clear asynchronously: state=IDLE, m_valid=0, m_byte=0, grant=0, s_ready=0, err_pulse=0, msg_count=0, last-served=feed 1.
REQ-033 Reset mid-message drops the partial message; no err_pulse is issued and m_valid is low in the first cycle after release.
REQ-034 Reset release is synchronised internally; the first grant occurs no earlier than the second edge after rst_n rises.

Structure
REQ-035 Package itch_arb_pkg holds the state enum, the default parameter constants, and the feed-index typedef.
REQ-036 Sub-module itch_rr_pick is a 2-way combinational round-robin selector taking the request vector and last-served feed and returning a one-hot grant.
REQ-037 Total RTL is 120-400 lines; no memories and no FIFOs.

Verification
REQ-038 Feed 0 sends Delete 'D' = 44 01 02 03 04 05 06 07 08 (s_last on 08) -> m_byte gives the same 9 bytes on consecutive cycles one cycle later, msg_count=1, then 2 idle cycles.
REQ-039 Both feeds request simultaneously after reset with 9-byte messages -> feed 0 is forwarded first, then after the gap feed 1; grant goes 01 -> 00 -> 10.
REQ-040 Feed 1 streams 70 bytes with no s_last -> 64 bytes are forwarded, err_pulse occurs once, msg_count is unchanged, s_ready[1]=0 from byte 65.
REQ-041 Feed 0 sends 3 bytes then holds s_valid low -> err_pulse occurs on the 8th stall cycle, then GAP and IDLE.
REQ-042 rst_n is asserted after byte 4 of 9 -> all outputs are 0 immediately; after release a new message on feed 0 is forwarded intact.
REQ-043 s_last arrives on byte 64 -> no err_pulse and msg_count increments.
